// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   state_t    - transmitter FSM states (PARITY exists only when
//                UART_TX_PARITY_EN is defined)
//   START_BIT, STOP_BIT, IDLE_LEVEL - serial line levels
//   cnt_width  - baud counter width for a given CLKS_PER_BIT
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // $clog2(2) is 1, but clamp anyway so a degenerate value never yields a
  // zero-width counter.
  function automatic int cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in serial-out register, LSB first.
//   clk, reset  - clock, async active-high reset (clears the register)
//   load        - capture data_in (has priority over shift_en)
//   shift_en    - shift right by one, zero filled
//   data_in     - parallel word
//   serial_bit  - bit currently at the output position (reg[0])
//   next_bit    - bit that will be at the output after the next shift (reg[1])
module piso_shift_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] data_in,
  output logic         serial_bit,
  output logic         next_bit
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sr <= '0;
    else if (load)     sr <= data_in;
    else if (shift_en) sr <= {1'b0, sr[W-1:1]};
  end

  assign serial_bit = sr[0];
  // The owner registers its line output, so it needs the post-shift bit one
  // cycle early.
  assign next_bit   = sr[1];

endmodule

// File: rtl/uart_tx_piso.sv
// uart_tx_piso: UART transmitter. Accepts a byte on a valid/ready handshake
// and sends start(0), INPUT_DATA_WIDTH data bits LSB first, optional even
// parity, stop(1). Each bit lasts CLKS_PER_BIT clocks.
//   clk, reset  - clock, async active-high reset (aborts any frame)
//   tx_data     - parallel byte, captured when tx_valid && tx_ready
//   tx_valid    - tx_data valid
//   tx_ready    - ready for a byte (high in IDLE and in the last stop cycle)
//   serial_out  - UART line, idle high, registered
//   tx_busy     - inverse of tx_ready
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_piso
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy
);

  localparam int W     = INPUT_DATA_WIDTH;
  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       IDX_LAST = 3'(W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             sr_bit, sr_next;
  logic             accept, bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  // tx_ready is only high in IDLE or the final stop cycle, so this single
  // term covers both the normal and the back-to-back acceptance.
  assign accept  = tx_valid && tx_ready;
  assign bit_end = (cnt == LAST);
  assign tx_busy = ~tx_ready;

  piso_shift_register #(.W(W)) u_piso (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .shift_en   (state == DATA && bit_end),
    .data_in    (tx_data),
    .serial_bit (sr_bit),
    .next_bit   (sr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      serial_out <= IDLE_LEVEL;
      tx_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else if (accept) begin
      state      <= START;
      cnt        <= '0;
      idx        <= '0;
      serial_out <= START_BIT;
      tx_ready   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= ^tx_data;
`endif
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:  serial_out <= IDLE_LEVEL;
        START: if (bit_end) begin
          state      <= DATA;
          serial_out <= sr_bit;
        end
        DATA: if (bit_end) begin
          if (idx == IDX_LAST) begin
            idx <= '0;
`ifdef UART_TX_PARITY_EN
            state      <= PARITY;
            serial_out <= parity;
`else
            state      <= STOP;
            serial_out <= STOP_BIT;
`endif
          end else begin
            idx        <= idx + 1'b1;
            serial_out <= sr_next;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state      <= STOP;
          serial_out <= STOP_BIT;
        end
`endif
        STOP: begin
          // Raise ready one cycle early so a waiting byte is taken at the
          // end of the stop bit without an extra idle cycle.
          if (cnt == PRE_LAST) tx_ready <= 1'b1;
          if (bit_end)         state    <= IDLE;
        end
        default: begin
          state      <= IDLE;
          serial_out <= IDLE_LEVEL;
          tx_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
